// File: rtl/program_counter_unit_pkg.sv
// pc_pkg
//   Shared definitions for the program counter unit and its return-address
//   stack: default vectors, the instruction-size decode and the RAS
//   pointer/count width helpers.
//   No ports (package).
package pc_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEFAULT_RAS_DEPTH    = 4;

  // Source selected for the next PC value.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_TARGET,
    SEL_RAS,
    SEL_TRAP
  } pc_sel_e;

  // A zero-length instruction still has to make forward progress.
  function automatic logic [31:0] decode_size(input logic [31:0] raw);
    return (raw == 32'd0) ? 32'd1 : raw;
  endfunction

  // Pointer width for a circular stack of the given (power-of-two) depth.
  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must be able to represent 0..depth inclusive.
  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/program_counter_unit_ras.sv
// return_address_stack
//   Circular return-address stack. A push onto a full stack overwrites the
//   oldest entry, so the stack always keeps the newest RAS_DEPTH addresses.
//   Ports:
//     clk, reset      - clock, synchronous active-high reset
//     push            - write push_data above the current top
//     pop             - discard the current top (no effect when empty)
//     swap            - replace the top with push_data (acts as push when empty)
//     push_data       - address to write
//     top             - current top entry (undefined when empty)
//     empty, full     - occupancy is 0 / occupancy is RAS_DEPTH
module return_address_stack
  import pc_pkg::*;
#(
  parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam int CNT_W = ras_cnt_w(RAS_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] entries [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] top_ptr_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             wr_en;

  // Pointer arithmetic wraps naturally because the depth is a power of two;
  // a push at full occupancy therefore lands on the oldest slot.
  always_comb begin
    top_ptr_next = top_ptr;
    count_next   = count;
    wr_ptr       = top_ptr;
    wr_en        = 1'b0;
    if (swap) begin
      wr_en = 1'b1;
      if (count == '0) begin
        top_ptr_next = top_ptr + PTR_ONE;
        wr_ptr       = top_ptr + PTR_ONE;
        count_next   = CNT_ONE;
      end
    end else if (push) begin
      wr_en        = 1'b1;
      top_ptr_next = top_ptr + PTR_ONE;
      wr_ptr       = top_ptr + PTR_ONE;
      if (count != DEPTH_C) begin
        count_next = count + CNT_ONE;
      end
    end else if (pop && (count != '0)) begin
      top_ptr_next = top_ptr - PTR_ONE;
      count_next   = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_ptr <= '0;
      count   <= '0;
    end else begin
      top_ptr <= top_ptr_next;
      count   <= count_next;
    end
  end

  // Entry storage needs no reset: occupancy guards every read that matters.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries[wr_ptr] <= push_data;
    end
  end

  assign top   = entries[top_ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit
//   Architectural fetch PC. Advances by a variable instruction size and
//   handles branch, trap, stall and call/return prediction via an internal
//   return-address stack.
//   Ports:
//     clk, reset        - clock, synchronous active-high reset
//     advance           - current instruction completes; apply its update
//     insn_size         - instruction length (0 treated as 1)
//     is_branch         - taken control transfer to branch_target
//     branch_target     - branch target; fallback target for a return
//     is_call           - with is_branch, push pc + size
//     is_ret            - return via RAS top
//     trap              - force PC to TRAP_VECTOR
//     stall             - hold all state
//     pc                - registered PC
//     redirect          - registered; high one cycle after a non-sequential load
//     ras_empty/ras_full- RAS occupancy 0 / RAS_DEPTH
//     ras_underflow     - registered pulse; a return found the RAS empty
module program_counter_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               SIZE_W       = 3,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int               RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [SIZE_W-1:0] insn_size,
  input  logic              is_branch,
  input  logic [WIDTH-1:0]  branch_target,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic              trap,
  input  logic              stall,
  output logic [WIDTH-1:0]  pc,
  output logic              redirect,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] size_val;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             redirect_next;
  logic             underflow_next;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_swap;

  assign size_val = WIDTH'(decode_size(32'(insn_size)));
  // Also the return address pushed by a call; wraps modulo 2^WIDTH.
  assign seq_pc   = pc + size_val;

  // Priority decode: trap beats stall beats advance. RAS control is only
  // raised on an unstalled, untrapped advance so the stack never moves
  // while the PC is held.
  always_comb begin
    sel            = SEL_HOLD;
    redirect_next  = 1'b0;
    underflow_next = 1'b0;
    ras_push       = 1'b0;
    ras_pop        = 1'b0;
    ras_swap       = 1'b0;
    if (trap) begin
      sel           = SEL_TRAP;
      redirect_next = 1'b1;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (advance) begin
      if (is_ret) begin
        redirect_next = 1'b1;
        sel           = ras_empty ? SEL_TARGET : SEL_RAS;
        if (is_call) begin
          // Coroutine swap: the old top is consumed and replaced in one go.
          ras_swap = 1'b1;
        end else if (ras_empty) begin
          underflow_next = 1'b1;
        end else begin
          ras_pop = 1'b1;
        end
      end else if (is_branch) begin
        sel           = SEL_TARGET;
        redirect_next = 1'b1;
        ras_push      = is_call;
      end else begin
        sel = SEL_SEQ;
      end
    end
  end

  always_comb begin
    pc_next = pc;
    case (sel)
      SEL_SEQ:    pc_next = seq_pc;
      SEL_TARGET: pc_next = branch_target;
      SEL_RAS:    pc_next = ras_top;
      SEL_TRAP:   pc_next = TRAP_VECTOR;
      default:    pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      redirect      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_next;
      redirect      <= redirect_next;
      ras_underflow <= underflow_next;
    end
  end

  return_address_stack #(
    .RAS_DEPTH(RAS_DEPTH),
    .WIDTH    (WIDTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .swap     (ras_swap),
    .push_data(seq_pc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
- Architectural PC register for the fetch stage.
- Each retired instruction advances the PC by a variable instruction size.
- Handles branch redirect, trap redirect, stall, and call/return prediction through an internal circular return-address stack (RAS).
- Sits between decode/retire control and the fetch address port. Supersedes the purely combinational PC+1 incrementer.

Parameters:
- WIDTH, 32: PC width in address units.
- SIZE_W, 3: width of insn_size.
- RESET_VECTOR, 0: PC value after reset.
- TRAP_VECTOR, 'h100: PC value loaded on trap.
- RAS_DEPTH, 4: return-address stack entries; power of two, at least 2.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- advance, in, 1: current instruction completes this cycle; apply its PC update.
- insn_size, in, SIZE_W: instruction length in address units; 0 is treated as 1.
- is_branch, in, 1: taken control transfer; qualified by advance.
- branch_target, in, WIDTH: target address for a branch; also the fallback target for a return.
- is_call, in, 1: with is_branch, push return address (pc + size).
- is_ret, in, 1: take target from the RAS top; implies a control transfer.
- trap, in, 1: force PC to TRAP_VECTOR.
- stall, in, 1: hold all state.
- pc, out, WIDTH: current PC, registered.
- redirect, out, 1: registered; 1 for one cycle after any non-sequential PC load (fetch flush).
- ras_empty, out, 1: RAS occupancy is 0.
- ras_full, out, 1: RAS occupancy equals RAS_DEPTH.
- ras_underflow, out, 1: registered pulse; a return found the RAS empty.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (the reset cycle overrides all other inputs):
  - pc = RESET_VECTOR
  - redirect = 0
  - RAS occupancy = 0, so ras_empty = 1 and ras_full = 0
  - ras_underflow = 0
- Per-cycle priority: reset > trap > stall > advance > hold.
- trap:
  - pc <= TRAP_VECTOR; redirect <= 1.
  - RAS untouched; trap overrides stall and advance in the same cycle.
- stall, with no trap: pc, RAS and occupancy hold; redirect <= 0; ras_underflow <= 0.
- advance=0: hold state; redirect <= 0.
- advance=1, sequential step (no is_branch, no is_ret):
  - pc <= pc + size, modulo 2^WIDTH; all-ones plus 1 wraps to 0.
  - size = insn_size, or 1 when insn_size = 0.
  - redirect <= 0.
- advance=1, is_branch without is_ret:
  - pc <= branch_target; redirect <= 1.
  - If is_call also set, push pc + size.
- Push when full: overwrite the oldest entry (circular). Occupancy stays at RAS_DEPTH; no error flag.
- advance=1, is_ret, RAS non-empty:
  - pc <= RAS top; pop; redirect <= 1.
  - is_branch and branch_target are ignored.
- advance=1, is_ret, RAS empty:
  - pc <= branch_target; redirect <= 1.
  - ras_underflow <= 1 for one cycle; occupancy stays 0.
- is_call and is_ret together (coroutine swap):
  - pc <= top, or branch_target if empty; the top is then replaced by pc + size.
  - Net occupancy is unchanged if non-empty, and becomes 1 if empty.
  - No underflow pulse in this case.
- is_call without is_branch or is_ret: ignored (treated as a sequential step).
- Latency: pc updates at the clock edge after advance; no combinational path from inputs to outputs.
- ras_empty and ras_full derive from the registered occupancy count (0 to RAS_DEPTH; width clog2(RAS_DEPTH)+1).
- Reset mid-sequence: discards all RAS contents and any pending redirect or underflow flag.

Decomposition:
- pc_pkg: size-decode function (0 to 1), RAS pointer/count width helper, default vector constants.
- Sub-module return_address_stack (RAS_DEPTH, WIDTH):
  - Inputs: push, pop, swap, push_data.
  - Outputs: top, empty, full.
  - Circular top pointer; overwrite-oldest on full push.
- program_counter_unit holds the PC register, priority mux, redirect and underflow flags.

Test Plan:
- Reset: assert reset 1 cycle with advance=1 and trap=1 -> pc=0, redirect=0, ras_empty=1. Then 3 advances with sizes 4,2,0 -> pc=4,6,7.
- Wrap: WIDTH=8, pc=0xFE, advance with size 4 -> pc=0x02, redirect=0.
- Call/return: at pc=0x10, call size 4 to target 0x80 -> pc=0x80, occupancy 1. Return -> pc=0x14, ras_empty=1, redirect pulses each time.
- RAS overflow: RAS_DEPTH=4, 5 nested calls -> ras_full=1. 4 returns yield the newest 4 return addresses in LIFO order. A 5th return pops nothing: ras_underflow=1, pc=branch_target.
- Stall and trap priority:
  - stall=1 with advance and branch -> pc unchanged.
  - trap with stall and advance -> pc=0x100, RAS unchanged.
  - Next cycle redirect=0 if idle.
- Swap: occupancy 1 with top=0x40, pc=0x20, call+ret with size 2 -> pc=0x40, top=0x22, occupancy 1.
